keypad_scan_ctrl: RTL

Sequencing controller for the 4x3 keypad. It drives the row-select lines one row at a time and samples the column lines through an internal synchronizer. Each press is debounced, then registered exactly once and shifted into a two-digit history that feeds the dual seven-segment display path. It sits between the keypad pins and the display decoder/multiplexer, and replaces ad-hoc per-module scanning and debouncing with one state machine.

---
 rtl/keypad_scan_ctrl.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/keypad_scan_ctrl.sv
// 4x3 keypad scanner: row sequencing, column synchronizer, press/release debounce and two-digit history.
// Optional feature macro KEYPAD_STAR_HASH_EN: when defined, * and # register as 4'hE / 4'hF.
module keypad_scan_ctrl #(
    parameter int ROW_DWELL    = 256,
    parameter int DEBOUNCE_CNT = 50000
) (
    input  logic       int_osc,
    input  logic       reset,
    input  logic [2:0] col,
    output logic [3:0] r_sel,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic [3:0] digit_new,
    output logic [3:0] digit_old
);

    localparam int CNT_MAX = (ROW_DWELL > DEBOUNCE_CNT) ? ROW_DWELL : DEBOUNCE_CNT;
    localparam int CW      = $clog2(CNT_MAX) + 1;
    localparam logic [CW-1:0] DWELL_LAST = CW'(ROW_DWELL - 1);
    localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CNT - 1);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

`ifdef KEYPAD_STAR_HASH_EN
    localparam logic STAR_HASH_EN = 1'b1;
`else
    localparam logic STAR_HASH_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    row_q, row_d;
    logic [2:0]    pat_q, pat_d;
    logic [3:0]    r_sel_q, r_sel_d;
    logic          key_valid_q, key_valid_d;
    logic [3:0]    key_code_q, key_code_d;
    logic [3:0]    digit_new_q, digit_new_d;
    logic [3:0]    digit_old_q, digit_old_d;
    logic [2:0]    sync1_q;
    logic [2:0]    col_s_q;

    logic          col_pressed_s;
    logic          col_idle_s;
    logic [1:0]    cap_col_s;
    logic [3:0]    cap_code_s;
    logic          cap_is_sym_s;
    logic          reg_en_s;

    function automatic logic [1:0] first_low_col(input logic [2:0] pat);
        logic [1:0] c;
        if (!pat[0]) begin
            c = 2'd0;
        end else if (!pat[1]) begin
            c = 2'd1;
        end else begin
            c = 2'd2;
        end
        return c;
    endfunction

    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] c);
        logic [3:0] code;
        case ({row, c})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            default:  code = 4'h0;
        endcase
        return code;
    endfunction

    function automatic logic [3:0] row_drive(input logic [1:0] row);
        logic [3:0] drv;
        case (row)
            2'd0:    drv = 4'b1110;
            2'd1:    drv = 4'b1101;
            2'd2:    drv = 4'b1011;
            2'd3:    drv = 4'b0111;
            default: drv = 4'b1110;
        endcase
        return drv;
    endfunction

    assign col_pressed_s = ~(&col_s_q);
    assign col_idle_s    = &col_s_q;
    assign cap_col_s     = first_low_col(pat_q);
    assign cap_code_s    = key_map(row_q, cap_col_s);
    // * sits in column 0 and # in column 2 of the bottom row; only 0 (column 1) is a digit there.
    assign cap_is_sym_s  = (row_q == 2'd3) && (cap_col_s != 2'd1);
    assign reg_en_s      = STAR_HASH_EN || !cap_is_sym_s;

    // Two-flop synchronizer for the asynchronous column inputs; idles high like the pull-ups.
    always_ff @(posedge int_osc or posedge reset) begin
        if (reset) begin
            sync1_q <= 3'b111;
            col_s_q <= 3'b111;
        end else begin
            sync1_q <= col;
            col_s_q <= sync1_q;
        end
    end

    // State, counter, row and output registers.
    always_ff @(posedge int_osc or posedge reset) begin
        if (reset) begin
            state_q     <= ST_SCAN;
            cnt_q       <= '0;
            row_q       <= 2'd0;
            pat_q       <= 3'b111;
            r_sel_q     <= 4'b1110;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            digit_new_q <= 4'h0;
            digit_old_q <= 4'h0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            row_q       <= row_d;
            pat_q       <= pat_d;
            r_sel_q     <= r_sel_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            digit_new_q <= digit_new_d;
            digit_old_q <= digit_old_d;
        end
    end

    // Next-state logic for the scan / debounce / held / release sequence.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        row_d       = row_q;
        pat_d       = pat_q;
        r_sel_d     = r_sel_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        digit_new_d = digit_new_q;
        digit_old_d = digit_old_q;

        case (state_q)
            ST_SCAN: begin
                if (cnt_q == DWELL_LAST) begin
                    cnt_d = '0;
                    if (col_pressed_s) begin
                        pat_d   = col_s_q;
                        state_d = ST_DEBOUNCE;
                    end else begin
                        row_d   = row_q + 2'd1;
                        r_sel_d = row_drive(row_q + 2'd1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_DEBOUNCE: begin
                if (col_s_q != pat_q) begin
                    state_d = ST_SCAN;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                    if (reg_en_s) begin
                        key_valid_d = 1'b1;
                        key_code_d  = cap_code_s;
                        digit_old_d = digit_new_q;
                        digit_new_d = cap_code_s;
                    end else begin
                        key_valid_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_HELD: begin
                if (col_idle_s) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_HELD;
                end
            end
            ST_RELEASE: begin
                if (!col_idle_s) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ST_SCAN;
                    cnt_d   = '0;
                    row_d   = row_q + 2'd1;
                    r_sel_d = row_drive(row_q + 2'd1);
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_SCAN;
                cnt_d   = '0;
            end
        endcase
    end

    assign r_sel     = r_sel_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign digit_new = digit_new_q;
    assign digit_old = digit_old_q;

endmodule
